dmem_mmio_responder: RTL and testbench

//  Responder side of the processor data-memory port. Decodes address_dmem/data/wren from the pipeline
//  and returns q_dmem. Backs a word-addressed data RAM plus a small MMIO page for the Tetris game:

---
 rtl/dmem_mmio_responder.sv | 159 +++++++++++++++
 tb/tb_dmem_mmio_responder.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_mmio_responder
// Purpose  : Data-memory responder with a word RAM and the Tetris MMIO page.
// Revision : 1.0  initial release
// ============================================================================
module dmem_mmio_responder #(
   parameter int          RAM_ADDR_W  = 12,
   parameter logic [31:0] MMIO_BASE   = 32'h0000_1000,
   parameter int          NBTN        = 4,
   parameter logic [31:0] TIMER_RESET = 32'd1000000
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [31:0]     address_dmem,
   input  logic [31:0]     data,
   input  logic            wren,
   output logic [31:0]     q_dmem,
   input  logic [NBTN-1:0] btn_in,
   output logic [15:0]     led_out,
   output logic            tick_irq
);

   localparam int         c_RAM_WORDS   = 1 << RAM_ADDR_W;
   localparam logic [2:0] c_OFF_BTN     = 3'd0;
   localparam logic [2:0] c_OFF_CYC     = 3'd1;
   localparam logic [2:0] c_OFF_TRELOAD = 3'd2;
   localparam logic [2:0] c_OFF_TSTAT   = 3'd3;
   localparam logic [2:0] c_OFF_LED     = 3'd4;

   logic [31:0]           ram_q [c_RAM_WORDS];

   logic [31:0]           q_dmem_q,   q_dmem_d;
   logic [NBTN-1:0]       btn_s1_q,   btn_s2_q,  btn_s3_q;
   logic [NBTN-1:0]       btn_pend_q, btn_pend_d;
   logic [31:0]           cyc_q,      cyc_d;
   logic [31:0]           treload_q,  treload_d;
   logic [31:0]           tcnt_q,     tcnt_d;
   logic                  tflag_q,    tflag_d;
   logic [15:0]           led_q,      led_d;

   logic                  w_ram_sel;
   logic                  w_mmio_sel;
   logic [31:0]           w_mmio_off;
   logic [RAM_ADDR_W-1:0] w_ram_idx;
   logic                  w_rd_btn;
   logic                  w_wr_cyc;
   logic                  w_wr_treload;
   logic                  w_wr_tstat;
   logic                  w_wr_led;
   logic                  w_expire;
   logic [NBTN-1:0]       w_btn_rise;

   // ------------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------------
   assign w_ram_sel    = (address_dmem >> RAM_ADDR_W) == 32'd0;
   assign w_ram_idx    = address_dmem[RAM_ADDR_W-1:0];
   assign w_mmio_off   = address_dmem - MMIO_BASE;
   assign w_mmio_sel   = w_mmio_off < 32'd5;

   assign w_rd_btn     = w_mmio_sel && (w_mmio_off[2:0] == c_OFF_BTN);
   assign w_wr_cyc     = wren && w_mmio_sel && (w_mmio_off[2:0] == c_OFF_CYC);
   assign w_wr_treload = wren && w_mmio_sel && (w_mmio_off[2:0] == c_OFF_TRELOAD);
   assign w_wr_tstat   = wren && w_mmio_sel && (w_mmio_off[2:0] == c_OFF_TSTAT);
   assign w_wr_led     = wren && w_mmio_sel && (w_mmio_off[2:0] == c_OFF_LED);

   // ------------------------------------------------------------------------
   // Load data: every cycle is a read of the pre-edge state
   // ------------------------------------------------------------------------
   always_comb begin
      q_dmem_d = 32'd0;
      if (w_ram_sel) begin
         q_dmem_d = ram_q[w_ram_idx];
      end else if (w_mmio_sel) begin
         case (w_mmio_off[2:0])
            c_OFF_BTN:     q_dmem_d[NBTN-1:0] = btn_pend_q;
            c_OFF_CYC:     q_dmem_d = cyc_q;
            c_OFF_TRELOAD: q_dmem_d = treload_q;
            c_OFF_TSTAT:   q_dmem_d = {31'd0, tflag_q};
            c_OFF_LED:     q_dmem_d = {16'd0, led_q};
            default:       q_dmem_d = 32'd0;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Buttons: an edge seen on the same cycle as a clearing read must survive
   // ------------------------------------------------------------------------
   assign w_btn_rise = btn_s2_q & ~btn_s3_q;
   assign btn_pend_d = (btn_pend_q & ~{NBTN{w_rd_btn}}) | w_btn_rise;

   // ------------------------------------------------------------------------
   // Cycle counter, LED latch, gravity timer
   // ------------------------------------------------------------------------
   assign cyc_d    = w_wr_cyc ? data : cyc_q + 32'd1;
   assign led_d    = w_wr_led ? data[15:0] : led_q;
   assign w_expire = (treload_q != 32'd0) && (tcnt_q == 32'd1);

   always_comb begin
      treload_d = treload_q;
      tcnt_d    = tcnt_q;
      tflag_d   = tflag_q;
      if (treload_q != 32'd0) begin
         tcnt_d = (tcnt_q <= 32'd1) ? treload_q : tcnt_q - 32'd1;
      end
      if (w_wr_tstat) begin
         tflag_d = 1'b0;
      end
      if (w_expire) begin
         tflag_d = 1'b1;
      end
      if (w_wr_treload) begin
         treload_d = data;
         tcnt_d    = data;
      end
   end

   // ------------------------------------------------------------------------
   // Storage
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (wren && w_ram_sel && !reset) begin
         ram_q[w_ram_idx] <= data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q_dmem_q   <= 32'd0;
         btn_s1_q   <= '0;
         btn_s2_q   <= '0;
         btn_s3_q   <= '0;
         btn_pend_q <= '0;
         cyc_q      <= 32'd0;
         treload_q  <= TIMER_RESET;
         tcnt_q     <= TIMER_RESET;
         tflag_q    <= 1'b0;
         led_q      <= 16'd0;
      end else begin
         q_dmem_q   <= q_dmem_d;
         btn_s1_q   <= btn_in;
         btn_s2_q   <= btn_s1_q;
         btn_s3_q   <= btn_s2_q;
         btn_pend_q <= btn_pend_d;
         cyc_q      <= cyc_d;
         treload_q  <= treload_d;
         tcnt_q     <= tcnt_d;
         tflag_q    <= tflag_d;
         led_q      <= led_d;
      end
   end

   assign q_dmem   = q_dmem_q;
   assign led_out  = led_q;
   assign tick_irq = tflag_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_mmio_responder
// Purpose  : Scoreboard bench for dmem_mmio_responder against an event model.
// Revision : 1.0  initial release
// ============================================================================
module tb_dmem_mmio_responder;

   localparam logic [31:0] MMIO_BASE   = 32'h0000_1000;
   localparam logic [31:0] TIMER_RESET = 32'd40;
   localparam longint      RAM_WORDS   = 4096;
   localparam logic [31:0] A_BTN       = MMIO_BASE + 32'd0;
   localparam logic [31:0] A_CYC       = MMIO_BASE + 32'd1;
   localparam logic [31:0] A_TRL       = MMIO_BASE + 32'd2;
   localparam logic [31:0] A_TST       = MMIO_BASE + 32'd3;
   localparam logic [31:0] A_LED       = MMIO_BASE + 32'd4;
   localparam logic [31:0] A_IDLE      = 32'h0000_3000;

   logic        clk;
   logic        reset;
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;
   logic [3:0]  btn_in;
   logic [15:0] led_out;
   logic        tick_irq;

   dmem_mmio_responder #(
      .RAM_ADDR_W  (12),
      .MMIO_BASE   (MMIO_BASE),
      .NBTN        (4),
      .TIMER_RESET (TIMER_RESET)
   ) dut (
      .clock        (clk),
      .reset        (reset),
      .address_dmem (address_dmem),
      .data         (data),
      .wren         (wren),
      .q_dmem       (q_dmem),
      .btn_in       (btn_in),
      .led_out      (led_out),
      .tick_irq     (tick_irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [31:0] q;
      logic        q_known;
      logic [15:0] led;
      logic        tick;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   logic stop   = 1'b0;
   logic done   = 1'b0;

   // ------------------------------------------------------------------------
   // Reference model: RAM as a sparse map, timer as an absolute tick schedule
   // ------------------------------------------------------------------------
   logic [31:0] mem_m [int unsigned];
   logic        started = 1'b0;
   longint      edge_n  = 0;
   longint      next_tick;
   logic [31:0] trl_m, cyc_m, off_m;
   logic [3:0]  pend_m, h0, h1, h2, rise_m;
   logic [15:0] led_m;
   logic        flag_m, exp_m, is_ram, is_mm;
   exp_t        e_m;

   always @(posedge clk) begin
      if (!stop) begin
         if (reset) begin
            pend_m = 4'd0; h0 = 4'd0; h1 = 4'd0; h2 = 4'd0;
            cyc_m  = 32'd0; led_m = 16'd0; flag_m = 1'b0;
            trl_m  = TIMER_RESET;
            next_tick = edge_n + longint'(TIMER_RESET);
            e_m = '{q: 32'd0, q_known: 1'b1, led: 16'd0, tick: 1'b0};
            sb.push_back(e_m);
            started = 1'b1;
         end else if (started) begin
            off_m  = address_dmem - MMIO_BASE;
            is_ram = longint'(address_dmem) < RAM_WORDS;
            is_mm  = off_m < 32'd5;
            e_m.q_known = 1'b1;
            e_m.q = 32'd0;
            if (is_ram) begin
               if (mem_m.exists(address_dmem)) e_m.q = mem_m[address_dmem];
               else                            e_m.q_known = 1'b0;
            end else if (is_mm) begin
               case (off_m)
                  32'd0: e_m.q = {28'd0, pend_m};
                  32'd1: e_m.q = cyc_m;
                  32'd2: e_m.q = trl_m;
                  32'd3: e_m.q = {31'd0, flag_m};
                  default: e_m.q = {16'd0, led_m};
               endcase
            end
            // synced level lags the pin by two samples; rise compares to the sample before
            rise_m = h1 & ~h2;
            h2 = h1; h1 = h0; h0 = btn_in;
            pend_m = ((is_mm && off_m == 32'd0) ? 4'd0 : pend_m) | rise_m;
            cyc_m = (wren && is_mm && off_m == 32'd1) ? data : cyc_m + 32'd1;
            exp_m = (trl_m != 32'd0) && (edge_n == next_tick);
            if (exp_m) next_tick = edge_n + longint'(trl_m);
            if (wren && is_mm && off_m == 32'd3) flag_m = 1'b0;
            if (exp_m) flag_m = 1'b1;
            if (wren && is_mm && off_m == 32'd2) begin
               trl_m = data;
               next_tick = edge_n + longint'(data);
            end
            if (wren && is_mm && off_m == 32'd4) led_m = data[15:0];
            if (wren && is_ram) mem_m[address_dmem] = data;
            e_m.led  = led_m;
            e_m.tick = flag_m;
            sb.push_back(e_m);
         end
         edge_n++;
      end
   end

   // ------------------------------------------------------------------------
   // Monitor: one expected entry per clock edge, compared on the falling edge
   // ------------------------------------------------------------------------
   exp_t m;
   always @(negedge clk) begin
      if (sb.size() > 0) begin
         m = sb.pop_front();
         if (m.q_known) begin
            checks++;
            if (q_dmem !== m.q) begin
               errors++;
               $display("FAIL q_dmem t=%0t got=%h exp=%h", $time, q_dmem, m.q);
            end
         end
         checks++;
         if (led_out !== m.led) begin
            errors++;
            $display("FAIL led_out t=%0t got=%h exp=%h", $time, led_out, m.led);
         end
         checks++;
         if (tick_irq !== m.tick) begin
            errors++;
            $display("FAIL tick_irq t=%0t got=%b exp=%b", $time, tick_irq, m.tick);
         end
      end
      if (done) begin
         checks++;
         if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d exp=0", sb.size());
         end
         checks++;
         if (checks < 100) begin
            errors++;
            $display("FAIL coverage checks=%0d exp>=100", checks);
         end
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   logic [3:0]  btn_r = 4'd0;
   logic        rst_r = 1'b1;
   logic [31:0] ra, rd;
   logic        rw;
   int          k;

   task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w);
      address_dmem = a;
      data         = d;
      wren         = w;
      btn_in       = btn_r;
      reset        = rst_r;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(A_IDLE, 32'd0, 1'b0);
   endtask

   initial begin
      address_dmem = 32'd0; data = 32'd0; wren = 1'b0; btn_in = 4'd0; reset = 1'b1;
      repeat (3) @(negedge clk);
      rst_r = 1'b0;

      // RAM store then loads
      drive(32'd5, 32'hDEAD_BEEF, 1'b1);
      drive(32'd5, 32'd0, 1'b0);
      drive(32'd5, 32'd0, 1'b0);
      // read-during-write returns old word; unmapped MMIO offset ignored
      drive(32'd9, 32'h1111_2222, 1'b1);
      drive(32'd9, 32'd7, 1'b1);
      drive(32'd9, 32'd0, 1'b0);
      drive(MMIO_BASE + 32'd9, 32'hCAFE_F00D, 1'b1);
      drive(MMIO_BASE + 32'd9, 32'd0, 1'b0);

      // button pulse, read-to-clear, edge coinciding with a read
      btn_r = 4'b0100; idle(3);
      btn_r = 4'b0000; idle(2);
      drive(A_BTN, 32'd0, 1'b0);
      drive(A_BTN, 32'd0, 1'b0);
      idle(2);
      btn_r = 4'b0100; idle(2);
      drive(A_BTN, 32'd0, 1'b0);
      drive(A_BTN, 32'd0, 1'b0);
      drive(A_BTN, 32'd0, 1'b0);
      btn_r = 4'b0000; idle(3);

      // gravity timer
      drive(A_TRL, 32'd3, 1'b1);
      idle(10);
      drive(A_TST, 32'hFFFF_FFFF, 1'b1);
      idle(4);
      drive(A_TST, 32'd0, 1'b1);
      drive(A_TRL, 32'd0, 1'b1);
      drive(A_TST, 32'd0, 1'b1);
      idle(8);
      drive(A_TRL, 32'd0, 1'b0);

      // cycle counter wrap and LED latch
      drive(A_CYC, 32'hFFFF_FFFE, 1'b1);
      idle(1);
      drive(A_CYC, 32'd0, 1'b0);
      drive(A_CYC, 32'd0, 1'b0);
      drive(A_LED, 32'h1234_ABCD, 1'b1);
      drive(A_LED, 32'd0, 1'b0);

      // reset mid-operation
      drive(A_TRL, 32'd10, 1'b1);
      btn_r = 4'b0011; idle(4);
      drive(A_LED, 32'h0000_5A5A, 1'b1);
      rst_r = 1'b1;
      drive(A_LED, 32'h0000_FFFF, 1'b1);
      rst_r = 1'b0;
      btn_r = 4'b0000;
      drive(A_TRL, 32'd0, 1'b0);
      drive(A_BTN, 32'd0, 1'b0);
      drive(A_LED, 32'd0, 1'b0);

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         k = $urandom_range(0, 9);
         if (k <= 4)      ra = 32'($urandom_range(0, 15));
         else if (k <= 8) ra = MMIO_BASE + 32'($urandom_range(0, 5));
         else             ra = (($urandom_range(0, 1) == 0) ? 32'h0000_2000 : 32'hFFFF_FFF0)
                               + 32'($urandom_range(0, 7));
         rd = (ra == A_TRL) ? 32'($urandom_range(0, 6)) : $urandom;
         rw = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 7) == 0) btn_r = btn_r ^ (4'd1 << $urandom_range(0, 3));
         rst_r = ($urandom_range(0, 299) == 0);
         drive(ra, rd, rw);
      end
      rst_r = 1'b0;
      idle(2);

      @(posedge clk);
      #1 stop = 1'b1;
      @(negedge clk);
      #1 done = 1'b1;
   end

endmodule
`default_nettype wire
